// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the 5-stage pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    localparam int unsigned PC_STEP = 4;

    // The youngest producer holds the newest value, so EX/MEM beats MEM/WB.
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hazard_cmp
// Description : Matches one source register against the EX, MEM and WB
//               destinations; returns {ex, mem, wb} hit bits.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_cmp
    import pipe_pkg::*;
#(
    parameter int RIDX_W = 5
) (
    input  logic [RIDX_W-1:0] i_src,
    input  logic [RIDX_W-1:0] i_ex_rd,
    input  logic              i_ex_we,
    input  logic              i_ex_v,
    input  logic [RIDX_W-1:0] i_mem_rd,
    input  logic              i_mem_we,
    input  logic              i_mem_v,
    input  logic [RIDX_W-1:0] i_wb_rd,
    input  logic              i_wb_we,
    input  logic              i_wb_v,
    output logic [2:0]        o_match
);

    // Register 0 is hardwired, so it can never carry a dependency.
    logic w_src_nz;

    assign w_src_nz   = |i_src;
    assign o_match[2] = w_src_nz & i_ex_v  & i_ex_we  & (i_src == i_ex_rd);
    assign o_match[1] = w_src_nz & i_mem_v & i_mem_we & (i_src == i_mem_rd);
    assign o_match[0] = w_src_nz & i_wb_v  & i_wb_we  & (i_src == i_wb_rd);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : PC, stage valids, advance enables, interlocks, forwarding
//               selects, sticky halt and stall counter for a 5-stage core.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              RIDX_W   = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit              FWD_EN   = 1'b1,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ready,
    input  logic              dmem_busy,
    input  logic [RIDX_W-1:0] id_rs,
    input  logic [RIDX_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [RIDX_W-1:0] ex_rs,
    input  logic [RIDX_W-1:0] ex_rt,
    input  logic [RIDX_W-1:0] ex_rd,
    input  logic [RIDX_W-1:0] mem_rd,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_memread,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              wb_halt,
    output logic [XLEN-1:0]   pc,
    output logic              en_if,
    output logic              en_id,
    output logic              en_ex,
    output logic              en_mem,
    output logic              en_wb,
    output logic              v_id,
    output logic              v_ex,
    output logic              v_mem,
    output logic              v_wb,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [2:0] c_MODE_FREEZE    = 3'd0;
    localparam logic [2:0] c_MODE_MEMWAIT   = 3'd1;
    localparam logic [2:0] c_MODE_REDIRECT  = 3'd2;
    localparam logic [2:0] c_MODE_INTERLOCK = 3'd3;
    localparam logic [2:0] c_MODE_FETCHWAIT = 3'd4;
    localparam logic [2:0] c_MODE_RUN       = 3'd5;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [XLEN-1:0]  r_pc;
    logic             r_v_id;
    logic             r_v_ex;
    logic             r_v_mem;
    logic             r_v_wb;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_count;

    logic [2:0] w_id_rs_hit;
    logic [2:0] w_id_rt_hit;
    logic [2:0] w_ex_rs_hit;
    logic [2:0] w_ex_rt_hit;
    logic       w_interlock;
    logic [2:0] w_mode;
    logic       w_stall_inc;
    logic       w_unused_hits;

    hazard_cmp #(.RIDX_W(RIDX_W)) u_cmp_id_rs (
        .i_src   (id_rs),
        .i_ex_rd (ex_rd),  .i_ex_we (ex_regwrite),  .i_ex_v (r_v_ex),
        .i_mem_rd(mem_rd), .i_mem_we(mem_regwrite), .i_mem_v(r_v_mem),
        .i_wb_rd (wb_rd),  .i_wb_we (wb_regwrite),  .i_wb_v (r_v_wb),
        .o_match (w_id_rs_hit)
    );

    hazard_cmp #(.RIDX_W(RIDX_W)) u_cmp_id_rt (
        .i_src   (id_rt),
        .i_ex_rd (ex_rd),  .i_ex_we (ex_regwrite),  .i_ex_v (r_v_ex),
        .i_mem_rd(mem_rd), .i_mem_we(mem_regwrite), .i_mem_v(r_v_mem),
        .i_wb_rd (wb_rd),  .i_wb_we (wb_regwrite),  .i_wb_v (r_v_wb),
        .o_match (w_id_rt_hit)
    );

    hazard_cmp #(.RIDX_W(RIDX_W)) u_cmp_ex_rs (
        .i_src   (ex_rs),
        .i_ex_rd (ex_rd),  .i_ex_we (ex_regwrite),  .i_ex_v (r_v_ex),
        .i_mem_rd(mem_rd), .i_mem_we(mem_regwrite), .i_mem_v(r_v_mem),
        .i_wb_rd (wb_rd),  .i_wb_we (wb_regwrite),  .i_wb_v (r_v_wb),
        .o_match (w_ex_rs_hit)
    );

    hazard_cmp #(.RIDX_W(RIDX_W)) u_cmp_ex_rt (
        .i_src   (ex_rt),
        .i_ex_rd (ex_rd),  .i_ex_we (ex_regwrite),  .i_ex_v (r_v_ex),
        .i_mem_rd(mem_rd), .i_mem_we(mem_regwrite), .i_mem_v(r_v_mem),
        .i_wb_rd (wb_rd),  .i_wb_we (wb_regwrite),  .i_wb_v (r_v_wb),
        .o_match (w_ex_rt_hit)
    );

    // With forwarding only a load in EX must stall its consumer; without it
    // any in-flight producer does.
    generate
        if (FWD_EN) begin : g_fwd
            assign w_interlock = ex_memread &
                                 ((id_uses_rs & w_id_rs_hit[2]) |
                                  (id_uses_rt & w_id_rt_hit[2]));
            assign fwd_a = fwd_pick(w_ex_rs_hit[1], w_ex_rs_hit[0]);
            assign fwd_b = fwd_pick(w_ex_rt_hit[1], w_ex_rt_hit[0]);
        end else begin : g_no_fwd
            assign w_interlock = (id_uses_rs & (|w_id_rs_hit)) |
                                 (id_uses_rt & (|w_id_rt_hit));
            assign fwd_a = FWD_RF;
            assign fwd_b = FWD_RF;
        end
    endgenerate

    assign w_unused_hits = ^{w_id_rs_hit, w_id_rt_hit, w_ex_rs_hit, w_ex_rt_hit, ex_memread};

    always_comb begin
        w_mode = c_MODE_RUN;
        if (reset || r_halted) begin
            w_mode = c_MODE_FREEZE;
        end else if (dmem_busy) begin
            w_mode = c_MODE_MEMWAIT;
        end else if (redirect_valid) begin
            w_mode = c_MODE_REDIRECT;
        end else if (w_interlock) begin
            w_mode = c_MODE_INTERLOCK;
        end else if (!imem_ready) begin
            w_mode = c_MODE_FETCHWAIT;
        end
    end

    always_comb begin
        en_if       = 1'b0;
        en_id       = 1'b0;
        en_ex       = 1'b0;
        en_mem      = 1'b0;
        en_wb       = 1'b0;
        w_stall_inc = 1'b0;
        case (w_mode)
            c_MODE_MEMWAIT: begin
                w_stall_inc = 1'b1;
            end
            c_MODE_INTERLOCK: begin
                en_ex       = 1'b1;
                en_mem      = 1'b1;
                en_wb       = 1'b1;
                w_stall_inc = 1'b1;
            end
            c_MODE_FETCHWAIT: begin
                en_id       = 1'b1;
                en_ex       = 1'b1;
                en_mem      = 1'b1;
                en_wb       = 1'b1;
                w_stall_inc = 1'b1;
            end
            c_MODE_REDIRECT, c_MODE_RUN: begin
                en_if  = 1'b1;
                en_id  = 1'b1;
                en_ex  = 1'b1;
                en_mem = 1'b1;
                en_wb  = 1'b1;
            end
            default: begin
                en_if = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_v_id        <= 1'b0;
            r_v_ex        <= 1'b0;
            r_v_mem       <= 1'b0;
            r_v_wb        <= 1'b0;
            r_halted      <= 1'b0;
            r_stall_count <= '0;
        end else begin
            if (r_v_wb && wb_halt) begin
                r_halted <= 1'b1;
            end
            if (w_stall_inc && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            case (w_mode)
                c_MODE_REDIRECT: begin
                    r_pc    <= redirect_pc;
                    r_v_id  <= 1'b0;
                    r_v_ex  <= 1'b0;
                    r_v_mem <= 1'b0;
                    r_v_wb  <= r_v_mem;
                end
                c_MODE_INTERLOCK: begin
                    r_v_ex  <= 1'b0;
                    r_v_mem <= r_v_ex;
                    r_v_wb  <= r_v_mem;
                end
                c_MODE_FETCHWAIT: begin
                    r_v_id  <= 1'b0;
                    r_v_ex  <= r_v_id;
                    r_v_mem <= r_v_ex;
                    r_v_wb  <= r_v_mem;
                end
                c_MODE_RUN: begin
                    r_pc    <= r_pc + XLEN'(PC_STEP);
                    r_v_id  <= 1'b1;
                    r_v_ex  <= r_v_id;
                    r_v_mem <= r_v_ex;
                    r_v_wb  <= r_v_mem;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign v_id        = r_v_id;
    assign v_ex        = r_v_ex;
    assign v_mem       = r_v_mem;
    assign v_wb        = r_v_wb;
    assign halted      = r_halted;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Scoreboard bench for pipe_hazard_ctrl in forwarding,
//               full-interlock and narrow-counter configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready, dmem_busy;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs, id_uses_rt;
    logic        ex_regwrite, mem_regwrite, wb_regwrite, ex_memread;
    logic        redirect_valid, wb_halt;
    logic [31:0] redirect_pc;

    logic [31:0] pc1, pc0, pc2;
    logic        en_if1, en_id1, en_ex1, en_mem1, en_wb1;
    logic        en_if0, en_id0, en_ex0, en_mem0, en_wb0;
    logic        en_if2, en_id2, en_ex2, en_mem2, en_wb2;
    logic        v_id1, v_ex1, v_mem1, v_wb1;
    logic        v_id0, v_ex0, v_mem0, v_wb0;
    logic        v_id2, v_ex2, v_mem2, v_wb2;
    logic [1:0]  fwd_a1, fwd_b1, fwd_a0, fwd_b0, fwd_a2, fwd_b2;
    logic        halted1, halted0, halted2;
    logic [15:0] sc1, sc0;
    logic [1:0]  sc2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [57:0] exp_q[$];
    logic [3:0]  fwd_q[$];

    logic [57:0] snap1, snap0, snap2;
    assign snap1 = {pc1, v_id1, v_ex1, v_mem1, v_wb1, en_if1, en_id1, en_ex1, en_mem1, en_wb1, halted1, sc1};
    assign snap0 = {pc0, v_id0, v_ex0, v_mem0, v_wb0, en_if0, en_id0, en_ex0, en_mem0, en_wb0, halted0, sc0};
    assign snap2 = {pc2, v_id2, v_ex2, v_mem2, v_wb2, en_if2, en_id2, en_ex2, en_mem2, en_wb2, halted2, 14'd0, sc2};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.XLEN(32), .RIDX_W(5), .RESET_PC(32'h100), .FWD_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .wb_halt(wb_halt), .pc(pc1),
        .en_if(en_if1), .en_id(en_id1), .en_ex(en_ex1), .en_mem(en_mem1), .en_wb(en_wb1),
        .v_id(v_id1), .v_ex(v_ex1), .v_mem(v_mem1), .v_wb(v_wb1),
        .fwd_a(fwd_a1), .fwd_b(fwd_b1), .halted(halted1), .stall_count(sc1)
    );

    pipe_hazard_ctrl #(.XLEN(32), .RIDX_W(5), .RESET_PC(32'h100), .FWD_EN(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .wb_halt(wb_halt), .pc(pc0),
        .en_if(en_if0), .en_id(en_id0), .en_ex(en_ex0), .en_mem(en_mem0), .en_wb(en_wb0),
        .v_id(v_id0), .v_ex(v_ex0), .v_mem(v_mem0), .v_wb(v_wb0),
        .fwd_a(fwd_a0), .fwd_b(fwd_b0), .halted(halted0), .stall_count(sc0)
    );

    pipe_hazard_ctrl #(.XLEN(32), .RIDX_W(5), .RESET_PC(32'h100), .FWD_EN(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .wb_halt(wb_halt), .pc(pc2),
        .en_if(en_if2), .en_id(en_id2), .en_ex(en_ex2), .en_mem(en_mem2), .en_wb(en_wb2),
        .v_id(v_id2), .v_ex(v_ex2), .v_mem(v_mem2), .v_wb(v_wb2),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .halted(halted2), .stall_count(sc2)
    );

    // Expected snapshot: {pc, v_id/ex/mem/wb, en_if/id/ex/mem/wb, halted, stall_count}
    function automatic logic [57:0] mk(input logic [31:0] p, input logic [3:0] v,
                                       input logic [4:0] e, input logic h, input logic [15:0] s);
        return {p, v, e, h, s};
    endfunction

    task automatic clear_inputs();
        imem_ready = 1'b1; dmem_busy = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        ex_regwrite = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0; ex_memread = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; wb_halt = 1'b0;
    endtask

    // Leaves every instance at pc=0x110 with all four stages valid.
    task automatic reset_and_fill();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [57:0] e;
        reset = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            reset = (i == 0);
            case (i)
                0: exp_q.push_back(mk(32'h100, 4'b0000, 5'b00000, 1'b0, 16'd0));
                1: exp_q.push_back(mk(32'h100, 4'b0000, 5'b11111, 1'b0, 16'd0));
                2: exp_q.push_back(mk(32'h104, 4'b1000, 5'b11111, 1'b0, 16'd0));
                3: exp_q.push_back(mk(32'h108, 4'b1100, 5'b11111, 1'b0, 16'd0));
                4: exp_q.push_back(mk(32'h10C, 4'b1110, 5'b11111, 1'b0, 16'd0));
                default: exp_q.push_back(mk(32'h110, 4'b1111, 5'b11111, 1'b0, 16'd0));
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap1 !== e) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %h expected %h", i, snap1, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forwarding();
        logic [3:0] e;
        reset_and_fill();
        for (int i = 0; i < 4; i++) begin
            mem_regwrite = 1'b1; wb_regwrite = 1'b1;
            case (i)
                0: begin mem_rd = 5'd5; wb_rd = 5'd5; ex_rs = 5'd5; ex_rt = 5'd0; fwd_q.push_back({2'd1, 2'd0}); end
                1: begin mem_rd = 5'd5; wb_rd = 5'd7; ex_rs = 5'd5; ex_rt = 5'd7; fwd_q.push_back({2'd1, 2'd2}); end
                2: begin mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; fwd_q.push_back({2'd0, 2'd0}); end
                default: begin
                    mem_rd = 5'd5; mem_regwrite = 1'b0; wb_rd = 5'd5; ex_rs = 5'd5; ex_rt = 5'd5;
                    fwd_q.push_back({2'd2, 2'd2});
                end
            endcase
            @(negedge clk);
            e = fwd_q.pop_front();
            n_cmp++;
            if ({fwd_a1, fwd_b1} !== e) begin
                n_bad++;
                $display("FAIL fwd[%0d]: got a=%0d b=%0d expected a=%0d b=%0d", i, fwd_a1, fwd_b1, e[3:2], e[1:0]);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [57:0] e;
        reset_and_fill();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    ex_memread = 1'b1; ex_rd = 5'd8; ex_regwrite = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
                    exp_q.push_back(mk(32'h110, 4'b1111, 5'b00111, 1'b0, 16'd1 - 16'd1));
                end
                1: begin
                    id_rs = 5'd8; id_uses_rs = 1'b1;
                    exp_q.push_back(mk(32'h110, 4'b1011, 5'b11111, 1'b0, 16'd1));
                end
                2: exp_q.push_back(mk(32'h114, 4'b1101, 5'b11111, 1'b0, 16'd1));
                3: begin
                    ex_rd = 5'd8; ex_regwrite = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
                    exp_q.push_back(mk(32'h118, 4'b1110, 5'b11111, 1'b0, 16'd1));
                end
                4: begin
                    ex_memread = 1'b1; ex_rd = 5'd8; ex_regwrite = 1'b1; id_rs = 5'd8; id_uses_rt = 1'b1;
                    exp_q.push_back(mk(32'h11C, 4'b1111, 5'b11111, 1'b0, 16'd1));
                end
                default: begin
                    ex_memread = 1'b1; ex_rd = 5'd0; ex_regwrite = 1'b1; id_rs = 5'd0; id_uses_rs = 1'b1;
                    exp_q.push_back(mk(32'h120, 4'b1111, 5'b11111, 1'b0, 16'd1));
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap1 !== e) begin
                n_bad++;
                $display("FAIL load_use[%0d]: got %h expected %h", i, snap1, e);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_fetch_wait();
        logic [57:0] e;
        reset_and_fill();
        for (int i = 0; i < 4; i++) begin
            imem_ready = (i >= 2);
            case (i)
                0: exp_q.push_back(mk(32'h110, 4'b1111, 5'b01111, 1'b0, 16'd0));
                1: exp_q.push_back(mk(32'h110, 4'b0111, 5'b01111, 1'b0, 16'd1));
                2: exp_q.push_back(mk(32'h110, 4'b0011, 5'b11111, 1'b0, 16'd2));
                default: exp_q.push_back(mk(32'h114, 4'b1001, 5'b11111, 1'b0, 16'd2));
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap1 !== e) begin
                n_bad++;
                $display("FAIL fetch_wait[%0d]: got %h expected %h", i, snap1, e);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_redirect_busy();
        logic [57:0] e;
        reset_and_fill();
        for (int i = 0; i < 6; i++) begin
            redirect_valid = (i <= 3);
            redirect_pc    = 32'h40;
            dmem_busy      = (i <= 2);
            case (i)
                0, 1, 2: exp_q.push_back(mk(32'h110, 4'b1111, 5'b00000, 1'b0, 16'(i)));
                3: exp_q.push_back(mk(32'h110, 4'b1111, 5'b11111, 1'b0, 16'd3));
                4: exp_q.push_back(mk(32'h40, 4'b0001, 5'b11111, 1'b0, 16'd3));
                default: exp_q.push_back(mk(32'h44, 4'b1000, 5'b11111, 1'b0, 16'd3));
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap1 !== e) begin
                n_bad++;
                $display("FAIL redirect_busy[%0d]: got %h expected %h", i, snap1, e);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_pc_wrap();
        logic [57:0] e;
        reset_and_fill();
        for (int i = 0; i < 3; i++) begin
            redirect_valid = (i == 0);
            redirect_pc    = 32'hFFFF_FFFC;
            case (i)
                0: exp_q.push_back(mk(32'h110, 4'b1111, 5'b11111, 1'b0, 16'd0));
                1: exp_q.push_back(mk(32'hFFFF_FFFC, 4'b0001, 5'b11111, 1'b0, 16'd0));
                default: exp_q.push_back(mk(32'h0, 4'b1000, 5'b11111, 1'b0, 16'd0));
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap1 !== e) begin
                n_bad++;
                $display("FAIL pc_wrap[%0d]: got %h expected %h", i, snap1, e);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_no_fwd();
        logic [57:0] e;
        logic [3:0]  f;
        reset_and_fill();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            id_rt = 5'd3; id_uses_rt = 1'b1; ex_rs = 5'd3; ex_rt = 5'd3;
            case (i)
                0: begin
                    mem_rd = 5'd3; mem_regwrite = 1'b1;
                    exp_q.push_back(mk(32'h110, 4'b1111, 5'b00111, 1'b0, 16'd0));
                end
                1: begin
                    wb_rd = 5'd3; wb_regwrite = 1'b1;
                    exp_q.push_back(mk(32'h110, 4'b1011, 5'b00111, 1'b0, 16'd1));
                end
                2: exp_q.push_back(mk(32'h110, 4'b1001, 5'b11111, 1'b0, 16'd2));
                default: exp_q.push_back(mk(32'h114, 4'b1100, 5'b11111, 1'b0, 16'd2));
            endcase
            fwd_q.push_back(4'b0000);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap0 !== e) begin
                n_bad++;
                $display("FAIL no_fwd[%0d]: got %h expected %h", i, snap0, e);
            end
            f = fwd_q.pop_front();
            n_cmp++;
            if ({fwd_a0, fwd_b0} !== f) begin
                n_bad++;
                $display("FAIL no_fwd_sel[%0d]: got %h expected %h", i, {fwd_a0, fwd_b0}, f);
            end
            if (i == 0) begin
                n_cmp++;
                if ({fwd_a1, fwd_b1} !== 4'b0101) begin
                    n_bad++;
                    $display("FAIL fwd_mem_hit: got %h expected 5", {fwd_a1, fwd_b1});
                end
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        logic [57:0] e;
        reset_and_fill();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    wb_halt = 1'b1;
                    exp_q.push_back(mk(32'h110, 4'b1111, 5'b11111, 1'b0, 16'd0));
                end
                1: exp_q.push_back(mk(32'h114, 4'b1111, 5'b00000, 1'b1, 16'd0));
                default: begin
                    dmem_busy = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; imem_ready = 1'b0;
                    exp_q.push_back(mk(32'h114, 4'b1111, 5'b00000, 1'b1, 16'd0));
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap1 !== e) begin
                n_bad++;
                $display("FAIL halt[%0d]: got %h expected %h", i, snap1, e);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        logic [57:0] e;
        reset_and_fill();
        for (int i = 0; i < 7; i++) begin
            dmem_busy = (i < 6);
            if (i < 6) begin
                exp_q.push_back(mk(32'h110, 4'b1111, 5'b00000, 1'b0, (i < 3) ? 16'(i) : 16'd3));
            end else begin
                exp_q.push_back(mk(32'h110, 4'b1111, 5'b11111, 1'b0, 16'd3));
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap2 !== e) begin
                n_bad++;
                $display("FAIL saturation[%0d]: got %h expected %h", i, snap2, e);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_fetch_wait();
        test_redirect_busy();
        test_pc_wrap();
        test_no_fwd();
        test_halt();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
